// File: rtl/pe_ws_gen.sv
// rtl/pe_ws_gen.sv - weight-stationary systolic PE (shadow/active weight, MAC); PE_SAT_EN enables saturating add
module pe_ws_gen #(
    parameter int ACT_W = 9,
    parameter int WGT_W = 9,
    parameter int ACC_W = 32
) (
    input  logic             PE_clk,
    input  logic             PE_rst_n,
    input  logic             PE_mode,
    input  logic             PE_wgt_vld_in,
    input  logic [WGT_W-1:0] PE_wgt_in,
    output logic             PE_wgt_vld_out,
    output logic [WGT_W-1:0] PE_wgt_out,
    input  logic             PE_swap,
    input  logic             PE_act_vld_in,
    input  logic [ACT_W-1:0] PE_act_in,
    output logic             PE_act_vld_out,
    output logic [ACT_W-1:0] PE_act_out,
    input  logic [ACC_W-1:0] PE_psum_in,
    output logic             PE_psum_vld_out,
    output logic [ACC_W-1:0] PE_psum_out,
    input  logic             PE_clr_ovf,
    output logic             PE_ovf,
    output logic [1:0]       PE_wstate
);

    localparam int PROD_W = ACT_W + WGT_W;

    generate
        if (ACC_W < PROD_W + 1) begin : g_bad_acc_w
            $error("pe_ws_gen: ACC_W must be at least ACT_W+WGT_W+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        W_EMPTY  = 2'd0,
        W_SHADOW = 2'd1,
        W_ACTIVE = 2'd2,
        W_BOTH   = 2'd3
    } wstate_e;

    wstate_e           wstate_q, wstate_d;
    logic [WGT_W-1:0]  shadow_q, shadow_d;
    logic [WGT_W-1:0]  active_q, active_d;
    logic [WGT_W-1:0]  wgt_out_q, wgt_out_d;
    logic              wgt_vld_q, wgt_vld_d;
    logic [ACT_W-1:0]  act_out_q, act_out_d;
    logic              act_vld_q, act_vld_d;
    logic [ACC_W-1:0]  psum_out_q, psum_out_d;
    logic              psum_vld_q, psum_vld_d;
    logic              ovf_q, ovf_d;

    logic                     load, comp, do_swap, shadow_vld, active_vld, ovf_det;
    logic signed [WGT_W-1:0]  wgt_eff;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W:0]    sum_ext;
    logic [ACC_W-1:0]         psum_res;

    always_comb begin
        wstate_d   = wstate_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        wgt_out_d  = wgt_out_q;
        wgt_vld_d  = 1'b0;
        act_out_d  = act_out_q;
        act_vld_d  = 1'b0;
        psum_out_d = psum_out_q;
        psum_vld_d = 1'b0;

        shadow_vld = (wstate_q == W_SHADOW) || (wstate_q == W_BOTH);
        active_vld = (wstate_q == W_ACTIVE) || (wstate_q == W_BOTH);
        load       = PE_mode & PE_wgt_vld_in;
        comp       = ~PE_mode & PE_act_vld_in;
        do_swap    = PE_swap & shadow_vld;

        if (load) begin
            shadow_d  = PE_wgt_in;
            wgt_out_d = shadow_q;
            wgt_vld_d = shadow_vld;
        end
        if (do_swap) begin
            active_d = shadow_q;
        end

        unique case (wstate_q)
            W_EMPTY:  if (load) wstate_d = W_SHADOW;
            W_SHADOW: if (do_swap) wstate_d = load ? W_BOTH : W_ACTIVE;
            W_ACTIVE: if (load) wstate_d = W_BOTH;
            W_BOTH:   if (do_swap) wstate_d = load ? W_BOTH : W_ACTIVE;
            default:  wstate_d = W_EMPTY;
        endcase

        // MAC sees the pre-swap active weight; no active weight multiplies as zero
        wgt_eff  = active_vld ? $signed(active_q) : '0;
        prod     = PROD_W'($signed(PE_act_in)) * PROD_W'(wgt_eff);
        prod_ext = ACC_W'(prod);
        sum_ext  = (ACC_W+1)'($signed(PE_psum_in)) + (ACC_W+1)'(prod_ext);
        ovf_det  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

`ifdef PE_SAT_EN
        if (ovf_det) begin
            psum_res = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            psum_res = sum_ext[ACC_W-1:0];
        end
        ovf_d = (ovf_q & ~PE_clr_ovf) | (comp & ovf_det);
`else
        psum_res = sum_ext[ACC_W-1:0];
        ovf_d    = 1'b0;
`endif

        if (comp) begin
            act_out_d  = PE_act_in;
            act_vld_d  = 1'b1;
            psum_out_d = psum_res;
            psum_vld_d = 1'b1;
        end
    end

`ifndef PE_SAT_EN
    logic unused_nosat;
    assign unused_nosat = ^{PE_clr_ovf, ovf_det, sum_ext[ACC_W]};
`endif

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            wstate_q   <= W_EMPTY;
            shadow_q   <= '0;
            active_q   <= '0;
            wgt_out_q  <= '0;
            wgt_vld_q  <= 1'b0;
            act_out_q  <= '0;
            act_vld_q  <= 1'b0;
            psum_out_q <= '0;
            psum_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            wgt_out_q  <= wgt_out_d;
            wgt_vld_q  <= wgt_vld_d;
            act_out_q  <= act_out_d;
            act_vld_q  <= act_vld_d;
            psum_out_q <= psum_out_d;
            psum_vld_q <= psum_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign PE_wgt_vld_out  = wgt_vld_q;
    assign PE_wgt_out      = wgt_out_q;
    assign PE_act_vld_out  = act_vld_q;
    assign PE_act_out      = act_out_q;
    assign PE_psum_vld_out = psum_vld_q;
    assign PE_psum_out     = psum_out_q;
    assign PE_ovf          = ovf_q;
    assign PE_wstate       = wstate_q;

endmodule

// File: tb/tb_pe_ws_gen.sv
// tb/tb_pe_ws_gen.sv - self-checking bench for pe_ws_gen against a behavioural model
module tb_pe_ws_gen;

    localparam int ACT_W = 9;
    localparam int WGT_W = 9;
    localparam int ACC_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode = 1'b0;
    logic             wgt_vld_in = 1'b0;
    logic [WGT_W-1:0] wgt_in = '0;
    logic             swap = 1'b0;
    logic             act_vld_in = 1'b0;
    logic [ACT_W-1:0] act_in = '0;
    logic [ACC_W-1:0] psum_in = '0;
    logic             clr_ovf = 1'b0;
    logic             wgt_vld_out, act_vld_out, psum_vld_out, ovf;
    logic [WGT_W-1:0] wgt_out;
    logic [ACT_W-1:0] act_out;
    logic [ACC_W-1:0] psum_out;
    logic [1:0]       wstate;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    pe_ws_gen #(.ACT_W(ACT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) dut (
        .PE_clk(clk), .PE_rst_n(rst_n), .PE_mode(mode),
        .PE_wgt_vld_in(wgt_vld_in), .PE_wgt_in(wgt_in),
        .PE_wgt_vld_out(wgt_vld_out), .PE_wgt_out(wgt_out),
        .PE_swap(swap), .PE_act_vld_in(act_vld_in), .PE_act_in(act_in),
        .PE_act_vld_out(act_vld_out), .PE_act_out(act_out),
        .PE_psum_in(psum_in), .PE_psum_vld_out(psum_vld_out), .PE_psum_out(psum_out),
        .PE_clr_ovf(clr_ovf), .PE_ovf(ovf), .PE_wstate(wstate)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: two weight slots with presence bits, outputs as plain arithmetic
    bit                      m_has_act = 0, m_has_sh = 0;
    logic signed [WGT_W-1:0] m_active = '0, m_shadow = '0;
    logic                    e_wgt_vld = 0, e_act_vld = 0, e_psum_vld = 0, e_ovf = 0;
    logic [WGT_W-1:0]        e_wgt_out = '0;
    logic [ACT_W-1:0]        e_act_out = '0;
    logic [ACC_W-1:0]        e_psum_out = '0;
    bit                      m_load, m_comp, m_ov;
    longint                  m_w, m_full;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W-1));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_has_act = 0; m_has_sh = 0; m_active = '0; m_shadow = '0;
            e_wgt_vld = 0; e_act_vld = 0; e_psum_vld = 0; e_ovf = 0;
            e_wgt_out = '0; e_act_out = '0; e_psum_out = '0;
        end else begin
            m_load = mode && wgt_vld_in;
            m_comp = !mode && act_vld_in;
            m_ov   = 0;
            m_w    = m_has_act ? longint'(m_active) : 0;
            e_act_vld  = m_comp;
            e_psum_vld = m_comp;
            if (m_comp) begin
                m_full    = longint'($signed(psum_in)) + longint'($signed(act_in)) * m_w;
                e_act_out = act_in;
`ifdef PE_SAT_EN
                if (m_full > MAXV) begin
                    m_full = MAXV; m_ov = 1;
                end else if (m_full < MINV) begin
                    m_full = MINV; m_ov = 1;
                end
`endif
                e_psum_out = m_full[ACC_W-1:0];
            end
`ifdef PE_SAT_EN
            e_ovf = (e_ovf && !clr_ovf) || m_ov;
`else
            e_ovf = 0;
`endif
            e_wgt_vld = m_load && m_has_sh;
            if (m_load) e_wgt_out = m_shadow;
            if (swap && m_has_sh) begin
                m_active = m_shadow; m_has_act = 1; m_has_sh = 0;
            end
            if (m_load) begin
                m_shadow = wgt_in; m_has_sh = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("wgt_vld_out", wgt_vld_out, e_wgt_vld);
            check("wgt_out", wgt_out, e_wgt_out);
            check("act_vld_out", act_vld_out, e_act_vld);
            check("act_out", act_out, e_act_out);
            check("psum_vld_out", psum_vld_out, e_psum_vld);
            check("psum_out", psum_out, e_psum_out);
            check("ovf", ovf, e_ovf);
            check("wstate", wstate, {m_has_act, m_has_sh});
        end
    end

    task automatic idle();
        mode = 0; wgt_vld_in = 0; swap = 0; act_vld_in = 0; clr_ovf = 0;
    endtask

    task automatic load_wgt(input logic [WGT_W-1:0] w);
        idle(); mode = 1; wgt_vld_in = 1; wgt_in = w;
        @(negedge clk);
    endtask

    task automatic do_swap();
        idle(); swap = 1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset psum_out", psum_out, 0);
        check("reset wstate", wstate, 0);
        check("reset valids", {wgt_vld_out, act_vld_out, psum_vld_out, ovf}, 0);
        rst_n = 1;
        cmp_en = 1;

        // two pushes: second push emits the first weight
        load_wgt(9'd5);
        load_wgt(9'd7);
        check("push wgt_vld_out", wgt_vld_out, 1);
        check("push wgt_out", wgt_out, 5);
        check("push wstate", wstate, 1);

        // shadow=3, swap, act=-4, psum=10 -> -2
        load_wgt(9'd3);
        do_swap();
        idle(); act_vld_in = 1; act_in = 9'h1FC; psum_in = 32'd10;
        @(negedge clk);
        check("mac psum_out", psum_out, 64'hFFFF_FFFE);
        check("mac act_out", act_out, 9'h1FC);
        check("mac valids", {act_vld_out, psum_vld_out}, 2'b11);

        // compute with swap in same cycle uses old active weight
        load_wgt(9'd2);
        do_swap();
        load_wgt(9'd6);
        check("both wstate", wstate, 3);
        idle(); act_vld_in = 1; act_in = 9'd5; psum_in = 32'd0; swap = 1;
        @(negedge clk);
        check("swap+mac psum_out", psum_out, 10);
        check("swap+mac wstate", wstate, 2);
        swap = 0;
        @(negedge clk);
        check("post-swap psum_out", psum_out, 30);

        // accumulator overflow
        load_wgt(9'd255);
        do_swap();
        idle(); act_vld_in = 1; act_in = 9'd255; psum_in = 32'h7FFF_FFF0;
        @(negedge clk);
`ifdef PE_SAT_EN
        check("sat psum_out", psum_out, 32'h7FFF_FFFF);
        check("sat ovf", ovf, 1);
        idle();
        @(negedge clk);
        check("sat ovf sticky", ovf, 1);
        clr_ovf = 1;
        @(negedge clk);
        check("sat ovf cleared", ovf, 0);
`else
        check("wrap psum_out", psum_out, 32'h8000_FDF1);
        check("wrap ovf", ovf, 0);
`endif

        // async reset one cycle after an activation
        idle(); act_vld_in = 1; act_in = 9'd3; psum_in = 32'd100;
        @(negedge clk);
        idle();
        #2 rst_n = 0;
        #1;
        check("async rst psum_out", psum_out, 0);
        check("async rst act_out", act_out, 0);
        check("async rst wstate", wstate, 0);
        check("async rst valids", {wgt_vld_out, act_vld_out, psum_vld_out}, 0);
        @(negedge clk);
        rst_n = 1;
        act_vld_in = 1; act_in = 9'd7; psum_in = 32'd42;
        @(negedge clk);
        check("post-rst passthrough", psum_out, 42);
        check("post-rst psum_vld", psum_vld_out, 1);

        for (int i = 0; i < 3000; i++) begin
            mode       = 1'($urandom_range(0, 1));
            wgt_vld_in = 1'($urandom_range(0, 1));
            wgt_in     = 9'($urandom);
            swap       = ($urandom_range(0, 5) == 0);
            act_vld_in = 1'($urandom_range(0, 1));
            act_in     = 9'($urandom);
            clr_ovf    = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       psum_in = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
                1:       psum_in = 32'h8000_0000 + 32'($urandom_range(0, 255));
                default: psum_in = $urandom;
            endcase
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 0;
                @(negedge clk);
                #2 rst_n = 1;
            end
        end

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_ws_gen.md
PE_WS_GEN -- requirements
Module: pe_ws_gen

Interface
REQ-001 SHALL have parameter ACT_W, default 9: signed activation width.
REQ-002 SHALL have parameter WGT_W, default 9: signed weight width.
REQ-003 SHALL have parameter ACC_W, default 32: signed partial-sum width; ACC_W >= ACT_W+WGT_W+1 is required, and elaboration SHALL fail otherwise.
REQ-004 SHALL have port PE_clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port PE_rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port PE_mode, input, 1: 1 = weight-load, 0 = compute.
REQ-007 SHALL have ports PE_wgt_vld_in, input, 1 and PE_wgt_in, input, WGT_W: weight shift-chain input from above.
REQ-008 SHALL have ports PE_wgt_vld_out, output, 1 and PE_wgt_out, output, WGT_W: weight shift-chain output to below.
REQ-009 SHALL have port PE_swap, input, 1: single-cycle pulse that commits the shadow weight to active.
REQ-010 SHALL have ports PE_act_vld_in, input, 1 and PE_act_in, input, ACT_W: activation from the left.
REQ-011 SHALL have ports PE_act_vld_out, output, 1 and PE_act_out, output, ACT_W: activation forwarded to the right.
REQ-012 SHALL have port PE_psum_in, input, ACC_W: partial sum from above, qualified by PE_act_vld_in.
REQ-013 SHALL have ports PE_psum_vld_out, output, 1 and PE_psum_out, output, ACC_W: partial sum to below.
REQ-014 SHALL have ports PE_clr_ovf, input, 1: clears the overflow flag; and PE_ovf, output, 1: sticky overflow.
REQ-015 SHALL have port PE_wstate, output, 2: weight FSM state.

Function
REQ-016 Weight FSM states SHALL be W_EMPTY=0, W_SHADOW=1 (shadow only), W_ACTIVE=2 (active only), W_BOTH=3 (active and shadow).
REQ-017 Load (PE_mode=1, PE_wgt_vld_in=1): shadow<=PE_wgt_in; PE_wgt_out<=old shadow; PE_wgt_vld_out<=old shadow-valid; all registered with 1-cycle latency, so N pushes fill an N-deep column.
REQ-018 Load transitions: W_EMPTY->W_SHADOW; W_ACTIVE->W_BOTH; W_SHADOW and W_BOTH hold.
REQ-019 PE_wgt_vld_in SHALL be ignored when PE_mode=0; PE_wgt_vld_out SHALL be 0 in any cycle without a load.
REQ-020 Swap (PE_swap=1 with shadow valid): active<=shadow, shadow-valid<=0; W_SHADOW->W_ACTIVE and W_BOTH->W_ACTIVE; swap with no shadow valid SHALL be a no-op.
REQ-021 Swap and load in the same cycle: active<=old shadow and shadow<=PE_wgt_in; next state W_BOTH.
REQ-022 Compute (PE_mode=0, PE_act_vld_in=1): PE_psum_out<=PE_psum_in + sext(PE_act_in*active); PE_act_out<=PE_act_in; both valids asserted next cycle (1-cycle latency).
REQ-023 Compute with no active weight (W_EMPTY/W_SHADOW): weight SHALL be treated as 0, psum passes unchanged, valids still asserted.
REQ-024 Compute and swap in the same cycle: the MAC SHALL use the pre-swap active weight.
REQ-025 PE_act_vld_in SHALL be ignored when PE_mode=1; output valids SHALL be 0 in that case and in every non-compute cycle.
REQ-026 PE_act_out and PE_psum_out SHALL hold their last value when their valid is 0.
REQ-027 Product SHALL be a full-precision ACT_W+WGT_W signed product, sign-extended to ACC_W before the add.
REQ-028 PE_clr_ovf SHALL clear PE_ovf; a new overflow in the same cycle SHALL take priority and set it.

Reset
REQ-029 On PE_rst_n=0, asynchronously: all outputs 0, active=0, shadow=0, state W_EMPTY, PE_ovf=0.
REQ-030 Reset mid-load or mid-compute SHALL discard all in-flight data; the first valid after release SHALL be processed normally.

Configuration
REQ-031 With PE_SAT_EN defined: add overflow SHALL saturate to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set sticky PE_ovf.
REQ-032 With PE_SAT_EN undefined: sum SHALL wrap modulo 2^ACC_W, PE_ovf SHALL be tied 0, and PE_clr_ovf SHALL be ignored.

Verification
REQ-033 Mode=1, push 5 then 7 -> wstate 1, wgt_vld_out=1 with wgt_out=5 one cycle after the second push.
REQ-034 Shadow=3, swap, then act=-4, psum=10 -> one cycle later psum_out=-2, act_out=-4, both valids 1.
REQ-035 W_BOTH (active=2, shadow=6), act=5/psum=0 with swap in the same cycle -> psum_out=10; next act=5 -> psum_out=30.
REQ-036 PE_SAT_EN, ACC_W=32, psum_in=0x7FFFFFF0, act=255, weight=255 -> psum_out=0x7FFFFFFF, PE_ovf=1 until clr; without the macro -> wrapped sum, PE_ovf=0.
REQ-037 Reset asserted one cycle after an act valid -> all outputs 0 asynchronously, wstate 0; a compute after release -> psum passes through unchanged.
